// File: rtl/trace_chk_pkg.sv
// trace_chk_pkg: shared types for the commit trace checker.
// Holds the record kind codes, failure codes, expected-record layout,
// checker state encoding and the record compare helper.
package trace_chk_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  typedef enum logic [2:0] {
    FAIL_NONE      = 3'd0,
    FAIL_MISMATCH  = 3'd1,
    FAIL_UNDERFLOW = 3'd2,
    FAIL_LEFTOVER  = 3'd3,
    FAIL_TIMEOUT   = 3'd4
  } fail_e;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] tag;
    logic [15:0] value;
  } exp_rec_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // True when an observed event (kind, tag, value) equals the expected record.
  // Register events pass their 4-bit register number zero-extended, so a REG
  // record with any of tag[15:4] set can never match.
  function automatic logic rec_match(input exp_rec_t rec, input kind_e kind,
                                     input logic [15:0] tag, input logic [15:0] value);
    return (rec.kind == kind) && (rec.tag == tag) && (rec.value == value);
  endfunction

endpackage

// File: rtl/trace_chk_fifo.sv
// trace_chk_fifo: single-clock FIFO of expected records.
// One push per cycle, pop of 0, 1 or 2 entries per cycle, two read ports
// (head and head+1) and an occupancy count. A push is refused whenever the
// FIFO is full, even if a pop happens in the same cycle.
module trace_chk_fifo
  import trace_chk_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  exp_rec_t                 push_rec_i,
  input  logic [1:0]               pop_n_i,
  output exp_rec_t                 head_o,
  output exp_rec_t                 head1_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  exp_rec_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    push_ok  = push_i && (count_q != CW'(DEPTH));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + AW'(pop_n_i);
    count_d  = count_q - CW'(pop_n_i);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q - CW'(pop_n_i) + CW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_rec_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + AW'(1)];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares the processor's retirement trace (register
// writebacks, loads, stores) against a queue of expected records and reports
// a registered verdict once the run ends.
// Optional watchdog: define TRACE_CHK_TIMEOUT_EN to fail the run with a
// timeout code when cycle_count reaches TIMEOUT without a halt.
module commit_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_tag,
  input  logic [15:0] exp_value,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        halt,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [15:0] fail_index,
  output logic [15:0] inst_count,
  output logic [16:0] cycle_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  exp_rec_t        push_rec;
  exp_rec_t        head_rec;
  exp_rec_t        head1_rec;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic [1:0]      pop_n;

  state_e          state_q, state_d;
  logic [15:0]     popped_q, popped_d;
  logic [15:0]     inst_count_q, inst_count_d;
  logic [16:0]     cycle_count_q, cycle_count_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [2:0]      fail_code_q, fail_code_d;
  logic [15:0]     fail_index_q, fail_index_d;

  logic            mem_ev;
  kind_e           mem_kind;
  logic [15:0]     mem_val;
  logic [1:0]      n_ev;
  logic            ev0_ok;
  logic            ev1_ok;
  logic            underflow;

  assign push_rec = '{kind: kind_e'(exp_kind), tag: exp_tag, value: exp_value};

  trace_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (exp_valid),
    .push_rec_i (push_rec),
    .pop_n_i    (pop_n),
    .head_o     (head_rec),
    .head1_o    (head1_rec),
    .count_o    (fifo_count),
    .full_o     (fifo_full)
  );

  assign exp_ready = !fifo_full;

  // Order this cycle's events (REG first, then the memory event) and compare
  // them with the FIFO head and head+1. A load+store cycle counts as a store.
  always_comb begin
    mem_ev   = mem_read || mem_write;
    mem_kind = mem_write ? KIND_STORE : KIND_LOAD;
    mem_val  = mem_write ? mem_wdata : mem_rdata;
    n_ev     = {1'b0, reg_write} + {1'b0, mem_ev};
    if (reg_write) begin
      ev0_ok = rec_match(head_rec, KIND_REG, {12'h000, write_reg}, write_data);
      if (mem_ev) begin
        ev1_ok = rec_match(head1_rec, mem_kind, mem_addr, mem_val);
      end else begin
        ev1_ok = 1'b1;
      end
    end else begin
      ev1_ok = 1'b1;
      if (mem_ev) begin
        ev0_ok = rec_match(head_rec, mem_kind, mem_addr, mem_val);
      end else begin
        ev0_ok = 1'b1;
      end
    end
    // Only entries already queued count; a same-cycle push cannot cover an event.
    underflow = (CW'(n_ev) > fifo_count);
  end

  // Verdict FSM, counters and registered-output next values.
  always_comb begin
    state_d       = state_q;
    popped_d      = popped_q;
    inst_count_d  = inst_count_q;
    cycle_count_d = cycle_count_q;
    fail_code_d   = fail_code_q;
    fail_index_d  = fail_index_q;
    pop_n         = 2'd0;

    case (state_q)
      ST_RUN: begin
        if (cycle_count_q != 17'h1FFFF) begin
          cycle_count_d = cycle_count_q + 17'd1;
        end else begin
          cycle_count_d = cycle_count_q;
        end

        if ((halt || reg_write || mem_write) && (inst_count_q != 16'hFFFF)) begin
          inst_count_d = inst_count_q + 16'd1;
        end else begin
          inst_count_d = inst_count_q;
        end

        if (underflow) begin
          state_d      = ST_FAIL;
          fail_code_d  = FAIL_UNDERFLOW;
          fail_index_d = popped_q + 16'(fifo_count);
        end else if (!ev0_ok) begin
          state_d      = ST_FAIL;
          fail_code_d  = FAIL_MISMATCH;
          fail_index_d = popped_q;
        end else if (!ev1_ok) begin
          state_d      = ST_FAIL;
          fail_code_d  = FAIL_MISMATCH;
          fail_index_d = popped_q + 16'd1;
        end else begin
          pop_n    = n_ev;
          popped_d = popped_q + 16'(n_ev);
          if (halt) begin
            // Halt is judged after this cycle's events have been consumed.
            if (fifo_count == CW'(n_ev)) begin
              state_d = ST_PASS;
            end else begin
              state_d      = ST_FAIL;
              fail_code_d  = FAIL_LEFTOVER;
              fail_index_d = popped_q + 16'(n_ev);
            end
          end else begin
`ifdef TRACE_CHK_TIMEOUT_EN
            if (cycle_count_d >= 17'(TIMEOUT)) begin
              state_d      = ST_FAIL;
              fail_code_d  = FAIL_TIMEOUT;
              fail_index_d = popped_q + 16'(n_ev);
            end else begin
              state_d = ST_RUN;
            end
`else
            state_d = ST_RUN;
`endif
          end
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase

    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    if (state_d != ST_FAIL) begin
      fail_code_d  = FAIL_NONE;
      fail_index_d = 16'd0;
    end else begin
      fail_code_d  = fail_code_d;
      fail_index_d = fail_index_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      popped_q      <= 16'd0;
      inst_count_q  <= 16'd0;
      cycle_count_q <= 17'd0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= 3'd0;
      fail_index_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      popped_q      <= popped_d;
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      fail_index_q  <= fail_index_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign fail_index  = fail_index_q;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker: directed scenarios for commit_trace_checker.
// Stimulus pushes the expected verdict into a scoreboard queue; a monitor
// pops and compares it when the DUT raises done.
module tb_commit_trace_checker;
  import trace_chk_pkg::*;

  localparam int DEPTH = 16;
`ifdef TRACE_CHK_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 100000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [1:0]  exp_kind = 2'd0;
  logic [15:0] exp_tag = 16'd0;
  logic [15:0] exp_value = 16'd0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = 4'd0;
  logic [15:0] write_data = 16'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [15:0] mem_wdata = 16'd0;
  logic [15:0] mem_rdata = 16'd0;
  logic        halt = 1'b0;
  logic        done;
  logic        pass;
  logic [2:0]  fail_code;
  logic [15:0] fail_index;
  logic [15:0] inst_count;
  logic [16:0] cycle_count;

  typedef struct {
    string       name;
    logic        pass;
    logic [2:0]  code;
    logic [15:0] idx;
    logic [15:0] inst;
    logic [16:0] cyc;
  } verdict_t;

  verdict_t sb[$];
  verdict_t mon_v;
  int n_cmp = 0;
  int n_fail = 0;
  bit done_seen = 1'b0;

  commit_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_tag(exp_tag), .exp_value(exp_value),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .done(done), .pass(pass), .fail_code(fail_code), .fail_index(fail_index),
    .inst_count(inst_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the expected verdict and compare.
  always @(negedge clk) begin
    if (rst_n && done && !done_seen) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_verdict: got pass=%0d code=%0d, expected none", pass, fail_code);
      end else begin
        mon_v = sb.pop_front();
        check({mon_v.name, ".pass"},  32'(pass),        32'(mon_v.pass));
        check({mon_v.name, ".code"},  32'(fail_code),   32'(mon_v.code));
        check({mon_v.name, ".index"}, 32'(fail_index),  32'(mon_v.idx));
        check({mon_v.name, ".inst"},  32'(inst_count),  32'(mon_v.inst));
        check({mon_v.name, ".cycle"}, 32'(cycle_count), 32'(mon_v.cyc));
      end
    end
    done_seen = done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events;
    reg_write = 1'b0; write_reg = 4'd0; write_data = 16'd0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 16'd0;
    mem_wdata = 16'd0; mem_rdata = 16'd0; halt = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    exp_valid = 1'b0;
    clear_events();
    tick();
    tick();
    check("rst.done",       32'(done),        32'd0);
    check("rst.pass",       32'(pass),        32'd0);
    check("rst.fail_code",  32'(fail_code),   32'd0);
    check("rst.fail_index", 32'(fail_index),  32'd0);
    check("rst.inst",       32'(inst_count),  32'd0);
    check("rst.cycle",      32'(cycle_count), 32'd0);
    check("rst.exp_ready",  32'(exp_ready),   32'd1);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] t, input logic [15:0] v);
    exp_valid = 1'b1; exp_kind = k; exp_tag = t; exp_value = v;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic step(input logic rw, input logic [3:0] wr, input logic [15:0] wd,
                      input logic mr, input logic mw, input logic [15:0] a,
                      input logic [15:0] wdat, input logic [15:0] rdat, input logic h);
    reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = a;
    mem_wdata = wdat; mem_rdata = rdat; halt = h;
    tick();
    clear_events();
  endtask

  task automatic expect_verdict(input string name, input logic p, input logic [2:0] c,
                                input logic [15:0] i, input logic [15:0] n, input logic [16:0] y);
    verdict_t v;
    v.name = name; v.pass = p; v.code = c; v.idx = i; v.inst = n; v.cyc = y;
    sb.push_back(v);
  endtask

  task automatic wait_sb(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.no_verdict: got none after %0d cycles, expected a verdict", name, budget);
      sb.delete();
    end
  endtask

  initial begin
    // Matching REG + STORE in one cycle, then halt.
    do_reset();
    push(2'd0, 16'h0003, 16'h0005);
    push(2'd2, 16'h0010, 16'h0005);
    expect_verdict("pass_basic", 1'b1, 3'd0, 16'd0, 16'd2, 17'd4);
    step(1'b1, 4'd3, 16'h0005, 1'b0, 1'b1, 16'h0010, 16'h0005, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    wait_sb("pass_basic", 10);

    // Load data mismatch; then FAIL must stay put with frozen counters.
    do_reset();
    push(2'd1, 16'h0020, 16'hBEEF);
    expect_verdict("load_mismatch", 1'b0, 3'd1, 16'd0, 16'd0, 17'd2);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEE, 1'b0);
    wait_sb("load_mismatch", 10);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick();
    check("absorb.fail_code", 32'(fail_code),   32'd1);
    check("absorb.pass",      32'(pass),        32'd0);
    check("absorb.cycle",     32'(cycle_count), 32'd2);
    check("absorb.inst",      32'(inst_count),  32'd0);

    // Underflow: writeback with an empty FIFO; same-cycle push does not help.
    do_reset();
    expect_verdict("underflow", 1'b0, 3'd2, 16'd0, 16'd1, 17'd1);
    exp_valid = 1'b1; exp_kind = 2'd0; exp_tag = 16'h0001; exp_value = 16'h0007;
    step(1'b1, 4'd1, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    exp_valid = 1'b0;
    wait_sb("underflow", 10);

    // Leftover: three records, two consumed, then halt.
    do_reset();
    push(2'd0, 16'h0001, 16'h0011);
    push(2'd0, 16'h0002, 16'h0022);
    push(2'd0, 16'h0003, 16'h0033);
    expect_verdict("leftover", 1'b0, 3'd3, 16'd2, 16'd3, 17'd6);
    step(1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 4'd2, 16'h0022, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    wait_sb("leftover", 10);

    // Double pop, then a store mismatch in the second event slot.
    do_reset();
    push(2'd0, 16'h0004, 16'h0044);
    push(2'd1, 16'h0030, 16'h1234);
    push(2'd0, 16'h0005, 16'h0055);
    push(2'd2, 16'h0040, 16'h9999);
    expect_verdict("slot1_mismatch", 1'b0, 3'd1, 16'd3, 16'd2, 17'd6);
    step(1'b1, 4'd4, 16'h0044, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1234, 1'b0);
    step(1'b1, 4'd5, 16'h0055, 1'b0, 1'b1, 16'h0040, 16'h9998, 16'h0000, 1'b0);
    wait_sb("slot1_mismatch", 10);

    // mem_read together with mem_write is treated as a store.
    do_reset();
    push(2'd2, 16'h0050, 16'h0007);
    expect_verdict("rw_as_store", 1'b1, 3'd0, 16'd0, 16'd2, 17'd3);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0050, 16'h0007, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    wait_sb("rw_as_store", 10);

    // REG record with upper tag bits set never matches.
    do_reset();
    push(2'd0, 16'h0013, 16'h0005);
    expect_verdict("reg_tag_high", 1'b0, 3'd1, 16'd0, 16'd1, 17'd2);
    step(1'b1, 4'd3, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    wait_sb("reg_tag_high", 10);

    // Full FIFO back-pressure, refused push on full+pop, reset mid-run.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(2'd0, 16'(i), 16'(i * 3));
    check("full.exp_ready", 32'(exp_ready), 32'd0);
    exp_valid = 1'b1; exp_kind = 2'd0; exp_tag = 16'h000F; exp_value = 16'hAAAA;
    step(1'b1, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    exp_valid = 1'b0;
    check("after_pop.exp_ready", 32'(exp_ready), 32'd1);
    check("after_pop.done",      32'(done),      32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst.exp_ready", 32'(exp_ready), 32'd1);
    check("midrst.done",      32'(done),      32'd0);
    do_reset();
    expect_verdict("after_midrst", 1'b1, 3'd0, 16'd0, 16'd1, 17'd1);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    wait_sb("after_midrst", 10);

`ifdef TRACE_CHK_TIMEOUT_EN
    // Watchdog fires when cycle_count reaches TIMEOUT.
    do_reset();
    expect_verdict("timeout", 1'b0, 3'd4, 16'd0, 16'd0, 17'd50);
    wait_sb("timeout", 60);
`else
    // Without the watchdog an idle run keeps counting and never finishes.
    do_reset();
    repeat (20) tick();
    check("idle.cycle", 32'(cycle_count), 32'd20);
    check("idle.done",  32'(done),        32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
